ram_w_pingpong: RTL and testbench
=================================

Name: ram_w_pingpong

Overview:
- Parametrised successor to the single-bank weight RAM: two-bank ping-pong weight buffer.
- The loader fills one bank while the GEMM array streams weights from the other bank.
- The read side is a burst engine: a base address plus a length produce a valid/ready word stream, so the same weights can be replayed across many img2col tiles.
- Tracks each bank's full/empty state and flags protocol errors.

Parameters:
- DATA_WIDTH, 8, weight word width in bits.
- DEPTH, 256, words per bank; power of two, at least 4.
- ADDR_W, $clog2(DEPTH), address/length width (derived).
- LEN_W, ADDR_W+1, burst length width, so that rd_len = DEPTH is legal.

Ports:
- clka  in  1  clock; all logic on rising edge.
- rsta  in  1  synchronous active-high reset.
- wr_en  in  1  write strobe into the current write bank.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_last  in  1  qualified by wr_en; final word, closes the write bank.
- wr_ready  out  1  current write bank is EMPTY.
- rd_start  in  1  one-cycle pulse; launches a burst.
- rd_base  in  ADDR_W  burst start address, sampled on rd_start.
- rd_len  in  LEN_W  burst word count, sampled on rd_start.
- rd_valid  out  1  rd_data valid.
- rd_data  out  DATA_WIDTH  streamed weight word.
- rd_ready  in  1  consumer accepts the word.
- rd_busy  out  1  burst in progress.
- rd_done  out  1  one-cycle pulse after the last beat is accepted.
- rd_release  in  1  pulse; frees the read bank.
- bank_full  out  2  per-bank FULL flag.
- err  out  1  one-cycle pulse on any dropped request.

Behaviour:
- Reset: bank_full=0, wr_bank=0, rd_bank=0, rd_valid=0, rd_busy=0, rd_done=0, err=0, rd_data=0, wr_ready=1. Memory contents are not cleared.
- Reset mid-burst aborts the burst immediately. No rd_done is generated.
- Write accept: wr_en && !bank_full[wr_bank] writes mem[wr_bank][wr_addr]. Words may arrive in any order.
  - With wr_last, the same edge sets bank_full[wr_bank] and toggles wr_bank.
- Write drop: wr_en while the write bank is FULL drops the word and pulses err. Memory is unchanged.
- Burst launch: rd_start is accepted only if !rd_busy && bank_full[rd_bank]. Acceptance latches ptr=rd_base, remaining=rd_len, and sets rd_busy.
  - Otherwise the pulse is ignored and err pulses.
- rd_len=0: rd_busy high for one cycle, rd_done pulses the next cycle, zero beats.
- Read pipeline (one-cycle synchronous RAM):
  - issue = rd_busy && remaining>0 && (!rd_valid || rd_ready).
  - On issue: RAM read enable asserts, ptr <= ptr+1 modulo DEPTH (wraps from DEPTH-1 to 0), remaining decrements.
  - rd_valid <= issue whenever (!rd_valid || rd_ready); otherwise held.
  - rd_data comes from the RAM output register. It is held stable while rd_valid && !rd_ready.
- Timing: first word is valid 1 cycle after rd_start is accepted. Throughput is 1 word/cycle with rd_ready held high. No word is lost or duplicated under backpressure.
- Completion: when the final beat is accepted (rd_valid && rd_ready && remaining==0), rd_busy clears and rd_done pulses the following cycle.
- A FULL bank may be burst-read any number of times.
- Release: rd_release while !rd_busy && bank_full[rd_bank] clears bank_full[rd_bank] and toggles rd_bank.
  - While busy or while the bank is empty, the release is ignored and err pulses.
- Simultaneous events:
  - wr_last and rd_release on different banks in the same cycle both take effect.
  - With a single bank in play, release of the FULL read bank and a new write to the other bank are independent.
  - rd_start and rd_release in the same cycle: rd_start wins, the release is flagged as err.
- A write to the bank currently being read cannot occur, because that bank is FULL and is not the write bank.

Test Plan:
1. Reset, then write bank0 with addr 0..7 = 0x10..0x17, wr_last on addr 7 -> bank_full=01, wr_bank=1, wr_ready=1. rd_start base=0 len=8 with rd_ready=1 -> rd_data 0x10..0x17 on 8 consecutive cycles starting 1 cycle after start; rd_done pulses once.
2. Same data, rd_ready toggling 1,0,0,1,... -> the sequence is still exactly 0x10..0x17, and rd_data is stable whenever stalled.
3. DEPTH=8, base=6, len=4 -> words at addr 6,7,0,1 in that order. len=0 -> no rd_valid, rd_done one cycle later.
4. Ping-pong: fill bank0, then fill bank1 while bursting bank0 twice (both bursts identical). rd_release -> rd_bank=1, bank_full=10. Next burst returns bank1 data.
5. Errors: rd_start with bank empty -> err, no burst. Write while both banks FULL -> err, data unchanged. rd_release while busy -> err.
6. Assert rsta in the middle of a burst -> next cycle rd_valid=0, rd_busy=0, bank_full=00, no rd_done pulse.

Source files
------------

// File: rtl/ram_w_pingpong_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_w_pingpong_if
// Brief    : Write, burst-read and status bundle of the ping-pong weight RAM.
// Revision : 1.0
// ============================================================================
interface ram_w_pingpong_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LEN_W  = ADDR_W + 1;

    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_last;
    logic                  wr_ready;
    logic                  rd_start;
    logic [ADDR_W-1:0]     rd_base;
    logic [LEN_W-1:0]      rd_len;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_ready;
    logic                  rd_busy;
    logic                  rd_done;
    logic                  rd_release;
    logic [1:0]            bank_full;
    logic                  err;

    modport master (
        output wr_en, wr_addr, wr_data, wr_last,
        output rd_start, rd_base, rd_len, rd_ready, rd_release,
        input  wr_ready, rd_valid, rd_data, rd_busy, rd_done, bank_full, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_last,
        input  rd_start, rd_base, rd_len, rd_ready, rd_release,
        output wr_ready, rd_valid, rd_data, rd_busy, rd_done, bank_full, err
    );
endinterface
`default_nettype wire

// File: rtl/ram_w_pingpong.sv
`default_nettype none
// ============================================================================
// Module   : ram_w_pingpong
// Brief    : Two-bank weight buffer; loader fills one bank, burst engine streams the other.
// Revision : 1.0
// ============================================================================
module ram_w_pingpong #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  wire logic       clka,
    input  wire logic       rsta,
    ram_w_pingpong_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LEN_W  = ADDR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [2*DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;

    logic wr_acc, wr_drop, start_ok, rel_ok, adv, issue, finish;

    always_comb begin
        wr_acc   = bus.wr_en && !full_q[wr_bank_q];
        wr_drop  = bus.wr_en && full_q[wr_bank_q];
        start_ok = bus.rd_start && !busy_q && full_q[rd_bank_q];
        // A concurrent rd_start always takes priority over a release.
        rel_ok   = bus.rd_release && !bus.rd_start && !busy_q && full_q[rd_bank_q];
        adv      = !valid_q || bus.rd_ready;
        issue    = busy_q && (rem_q != '0) && adv;
        finish   = busy_q && (rem_q == '0) && adv;

        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        busy_d    = busy_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;

        if (wr_acc && bus.wr_last) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
        end
        if (rel_ok) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end

        if (start_ok) begin
            busy_d = 1'b1;
            ptr_d  = bus.rd_base;
            rem_d  = bus.rd_len;
        end else begin
            if (issue) begin
                ptr_d = ptr_q + 1'b1;
                rem_d = rem_q - 1'b1;
            end
            if (finish) begin
                busy_d = 1'b0;
            end
        end

        valid_d = adv ? issue : valid_q;
        done_d  = finish;
        err_d   = wr_drop || (bus.rd_start && !start_ok) || (bus.rd_release && !rel_ok);
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ptr_q     <= '0;
            rem_q     <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
        end
    end

    // Storage keeps its contents through reset; bank select is the top address bit.
    always_ff @(posedge clka) begin
        if (!rsta && wr_acc) begin
            mem_q[{wr_bank_q, bus.wr_addr}] <= bus.wr_data;
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            rd_data_q <= '0;
        end else if (issue) begin
            rd_data_q <= mem_q[{rd_bank_q, ptr_q}];
        end
    end

    assign bus.wr_ready  = !full_q[wr_bank_q];
    assign bus.rd_valid  = valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_busy   = busy_q;
    assign bus.rd_done   = done_q;
    assign bus.bank_full = full_q;
    assign bus.err       = err_q;
endmodule
`default_nettype wire

// File: tb/tb_ram_w_pingpong.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_w_pingpong
// Brief    : Random and directed stimulus against a transaction-level model of the buffer.
// Revision : 1.0
// ============================================================================
module tb_ram_w_pingpong;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int LW    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_w_pingpong_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();
    ram_w_pingpong #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clka (clk),
        .rsta (rst),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [DW-1:0] m_mem [2][DEPTH];
    logic [1:0]    m_full;
    logic          m_wb, m_rb, m_busy, m_fresh, m_done, m_err;
    logic          m_live = 1'b0;
    logic [DW-1:0] m_q [$];
    logic [DW-1:0] acc_log [$];
    logic          e_valid, e_acc, e_start, e_rel, e_errn;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: banks as arrays, a burst as a queue of words still owed to the consumer.
    always @(negedge clk) begin
        e_valid = m_busy && !m_fresh && (m_q.size() > 0);
        if (m_live) begin
            chk("bank_full", bus.bank_full, m_full);
            chk("wr_ready", bus.wr_ready, !m_full[m_wb]);
            chk("rd_busy", bus.rd_busy, m_busy);
            chk("rd_done", bus.rd_done, m_done);
            chk("err", bus.err, m_err);
            chk("rd_valid", bus.rd_valid, e_valid);
            if (e_valid) chk("rd_data", bus.rd_data, m_q[0]);
            if (bus.rd_done) done_cnt++;
        end
        e_acc = e_valid && bus.rd_ready;
        if (e_acc) acc_log.push_back(bus.rd_data);

        if (rst) begin
            m_live  = 1'b1;
            m_full  = 2'b00;
            m_wb    = 1'b0;
            m_rb    = 1'b0;
            m_busy  = 1'b0;
            m_fresh = 1'b0;
            m_done  = 1'b0;
            m_err   = 1'b0;
            m_q.delete();
        end else if (m_live) begin
            e_start = bus.rd_start && !m_busy && m_full[m_rb];
            e_rel   = bus.rd_release && !bus.rd_start && !m_busy && m_full[m_rb];
            e_errn  = (bus.wr_en && m_full[m_wb]) || (bus.rd_start && !e_start)
                      || (bus.rd_release && !e_rel);
            m_done  = 1'b0;
            if (m_busy) begin
                if (e_acc) void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
            m_fresh = 1'b0;
            if (e_start) begin
                for (int i = 0; i < int'(bus.rd_len); i++)
                    m_q.push_back(m_mem[m_rb][(int'(bus.rd_base) + i) % DEPTH]);
                m_busy  = 1'b1;
                m_fresh = 1'b1;
            end
            if (bus.wr_en && !m_full[m_wb]) begin
                m_mem[m_wb][bus.wr_addr] = bus.wr_data;
                if (bus.wr_last) begin
                    m_full[m_wb] = 1'b1;
                    m_wb         = !m_wb;
                end
            end
            if (e_rel) begin
                m_full[m_rb] = 1'b0;
                m_rb         = !m_rb;
            end
            m_err = e_errn;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int a, input int d, input bit last);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a[AW-1:0];
        bus.wr_data = d[DW-1:0];
        bus.wr_last = last;
        tick();
        bus.wr_en   = 1'b0;
        bus.wr_last = 1'b0;
    endtask

    task automatic fill_bank(input int base_val, input bit shuffle);
        int order [DEPTH];
        int j, t;
        for (int i = 0; i < DEPTH; i++) order[i] = i;
        if (shuffle) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                j = int'($urandom_range(0, i));
                t = order[i]; order[i] = order[j]; order[j] = t;
            end
        end
        for (int k = 0; k < DEPTH; k++)
            write_word(order[k], base_val + order[k], k == DEPTH - 1);
    endtask

    // mode 0: ready held high, 1: ready pattern 1,0,0 repeating, 2: random ready.
    task automatic burst(input int base, input int len, input int mode, input int rel_at);
        int n;
        n = 0;
        bus.rd_start = 1'b1;
        bus.rd_base  = base[AW-1:0];
        bus.rd_len   = len[LW-1:0];
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        while (bus.rd_busy && n < 200) begin
            case (mode)
                0:       bus.rd_ready = 1'b1;
                1:       bus.rd_ready = (n % 3 == 0);
                default: bus.rd_ready = 1'($urandom_range(0, 1));
            endcase
            bus.rd_release = (n == rel_at);
            tick();
            bus.rd_release = 1'b0;
            n++;
        end
        chk("burst_timeout", 32'(n >= 200), 32'd0);
        bus.rd_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic chk_log(input string name, input int first, input int start_addr, input int n);
        chk(name, acc_log.size(), n);
        for (int i = 0; i < n && i < acc_log.size(); i++)
            chk(name, acc_log[i], first + ((start_addr + i) % DEPTH));
        acc_log.delete();
    endtask

    int d0;

    initial begin
        rst            = 1'b1;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.wr_last    = 1'b0;
        bus.rd_start   = 1'b0;
        bus.rd_base    = '0;
        bus.rd_len     = '0;
        bus.rd_ready   = 1'b1;
        bus.rd_release = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_bank_full", bus.bank_full, 2'b00);
        chk("rst_wr_ready", bus.wr_ready, 1'b1);
        chk("rst_rd_data", bus.rd_data, 8'h00);
        chk("rst_rd_valid", bus.rd_valid, 1'b0);

        // Basic fill and full-speed burst.
        fill_bank(8'h10, 1'b0);
        chk("t1_bank_full", bus.bank_full, 2'b01);
        chk("t1_wr_ready", bus.wr_ready, 1'b1);
        acc_log.delete();
        d0 = done_cnt;
        burst(0, 8, 0, -1);
        chk_log("t1_data", 8'h10, 0, 8);
        chk("t1_done", done_cnt - d0, 1);

        // Backpressure.
        d0 = done_cnt;
        burst(0, 8, 1, -1);
        chk_log("t2_data", 8'h10, 0, 8);
        chk("t2_done", done_cnt - d0, 1);

        // Address wrap and zero-length burst.
        burst(6, 4, 0, -1);
        chk_log("t3_wrap", 8'h10, 6, 4);
        d0 = done_cnt;
        burst(0, 0, 0, -1);
        chk_log("t3_len0", 8'h10, 0, 0);
        chk("t3_len0_done", done_cnt - d0, 1);

        // Ping-pong: load bank1 while replaying bank0 twice.
        fork
            fill_bank(8'h20, 1'b1);
            begin
                burst(0, 8, 2, -1);
                burst(0, 8, 2, -1);
            end
        join
        chk("t4_replay_cnt", acc_log.size(), 16);
        for (int i = 0; i < 16 && i < acc_log.size(); i++)
            chk("t4_replay", acc_log[i], 8'h10 + (i % 8));
        acc_log.delete();
        bus.rd_release = 1'b1;
        tick();
        bus.rd_release = 1'b0;
        chk("t4_bank_full", bus.bank_full, 2'b10);
        burst(0, 8, 0, -1);
        chk_log("t4_bank1", 8'h20, 0, 8);

        // Error cases.
        bus.rd_release = 1'b1;
        tick();
        bus.rd_release = 1'b0;
        chk("t5_all_empty", bus.bank_full, 2'b00);
        bus.rd_start = 1'b1;
        bus.rd_base  = '0;
        bus.rd_len   = 4'd4;
        tick();
        bus.rd_start = 1'b0;
        chk("t5_start_err", bus.err, 1'b1);
        chk("t5_start_busy", bus.rd_busy, 1'b0);
        tick();
        chk("t5_err_pulse", bus.err, 1'b0);
        fill_bank(8'h30, 1'b0);
        fill_bank(8'h40, 1'b0);
        chk("t5_both_full", bus.bank_full, 2'b11);
        chk("t5_wr_ready", bus.wr_ready, 1'b0);
        write_word(0, 8'hFF, 1'b0);
        chk("t5_drop_err", bus.err, 1'b1);
        burst(0, 8, 0, 3);
        chk_log("t5_unchanged", 8'h30, 0, 8);
        chk("t5_still_full", bus.bank_full, 2'b11);

        // Reset in the middle of a burst.
        bus.rd_start = 1'b1;
        bus.rd_base  = '0;
        bus.rd_len   = 4'd8;
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valid", bus.rd_valid, 1'b0);
        chk("t6_busy", bus.rd_busy, 1'b0);
        chk("t6_full", bus.bank_full, 2'b00);
        d0 = done_cnt;
        tick();
        tick();
        chk("t6_no_done", done_cnt - d0, 0);
        acc_log.delete();

        // Randomized traffic.
        fill_bank(8'h50, 1'b1);
        fill_bank(8'h60, 1'b1);
        for (int c = 0; c < 1500; c++) begin
            rst            = ($urandom_range(0, 399) == 0);
            bus.wr_en      = !rst && ($urandom_range(0, 3) == 0);
            bus.wr_addr    = AW'($urandom_range(0, DEPTH - 1));
            bus.wr_data    = DW'($urandom);
            bus.wr_last    = ($urandom_range(0, 5) == 0);
            bus.rd_start   = ($urandom_range(0, 7) == 0);
            bus.rd_base    = AW'($urandom_range(0, DEPTH - 1));
            bus.rd_len     = LW'($urandom_range(0, DEPTH));
            bus.rd_ready   = ($urandom_range(0, 3) != 0);
            bus.rd_release = ($urandom_range(0, 15) == 0);
            tick();
        end
        rst            = 1'b0;
        bus.wr_en      = 1'b0;
        bus.rd_start   = 1'b0;
        bus.rd_release = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
